stream_demux1to2: RTL and testbench
===================================

# stream_demux1to2

Registered 1-to-2 stream demultiplexer, the inverse of the team's 2:1 mux. It takes one valid/ready input stream and steers each beat to one of two output streams under a per-beat select. A one-entry register slot sits on each output and gives a fixed 1-cycle latency. It sits wherever one producer must feed two consumers, for example splitting a shared bus toward two mux-tested datapaths.

## Interface
- WIDTH, 8, data width of every stream
- CNT_W, 8, width of each per-output beat counter
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- in_data  input  WIDTH  input beat payload
- in_select  input  1  route: 0 to out1, 1 to out2 (same encoding as the mux's select)
- in_last  input  1  marks last beat of a packet
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted when in_valid && in_ready
- out1_data / out2_data  output  WIDTH  slot payload
- out1_last / out2_last  output  1  slot last flag
- out1_valid / out2_valid  output  1  slot full
- out1_ready / out2_ready  input  1  consumer accepts when valid && ready
- out1_count / out2_count  output  CNT_W  beats delivered on each output

## Operation
- Each output owns one slot holding {data, last, valid}.
- The effective route `sel_eff` is in_select. Under packet lock it is the locked select instead (see Configuration).
- The target slot is writable if it is empty or draining this cycle (out_valid && out_ready).
- in_ready = writable(target). in_ready is combinational from in_select, out*_valid and out*_ready. It does not depend on in_valid.
- On accept, the target slot loads in_data and in_last and sets valid. The non-target slot is untouched.
- A slot drains on out_valid && out_ready. It clears valid unless it is reloaded in the same cycle.
- Counters increment on each drain (not on accept). They wrap from 2^CNT_W-1 to 0.
- Blocking: a beat for a full, non-draining slot stalls the input (in_ready=0). The other slot keeps draining independently.
- Data never reorders within one output. Beats routed to different outputs may be consumed in any relative order.

## Timing
- Latency: a beat accepted in cycle N is visible on the output in cycle N+1.
- Throughput: 1 beat/cycle per output while the consumer holds ready high. Simultaneous drain and reload of the same slot is required.
- Reset values: out*_valid=0, out*_data=0, out*_last=0, out*_count=0, lock FSM=IDLE. in_ready then reflects only the empty slots, so it is 1 after reset.
- Reset asserted mid-operation immediately clears all slots and counters. In-flight beats are discarded. No output valid glitches high during reset.
- out*_data and out*_last are held stable while valid && !ready.

## Configuration
- Macro: DEMUX_PKT_LOCK_EN.
- Defined: adds a 2-state FSM with states IDLE and LOCKED.
  - IDLE: sel_eff = in_select. An accepted beat with in_last=0 stores in_select into lock_sel and moves to LOCKED.
  - LOCKED: sel_eff = lock_sel and in_select is ignored. An accepted beat with in_last=1 returns the FSM to IDLE.
  - A single-beat packet (first beat has in_last=1) stays in IDLE.
  - Reset forces IDLE.
- Undefined: no FSM. sel_eff = in_select on every beat, and in_last is only carried through to the output.

## Structure
- Package demux_pkg holds:
  - SEL_OUT1=1'b0 and SEL_OUT2=1'b1
  - the lock state enum {LOCK_IDLE, LOCK_HELD}
- Sub-module demux_out_slot: a one-entry register slice holding the data/last/valid registers, the drain logic and the wrap counter. It takes WIDTH and CNT_W and is instantiated twice. The top level contains the routing, the in_ready logic and the optional FSM.

## Test plan
- Reset then route: after reset, drive in_data=8'hA5, select=0, valid=1 for 1 cycle with out1_ready=1. Expect out1_valid=1 and out1_data=A5 next cycle, out2_valid=0, and out1_count=1 after the drain.
- Exhaustive steering: for all 8 combinations of {data bit, select, last} with both readies=1, only the selected output fires, carrying the data and last unchanged (mirrors the mux check).
- Backpressure: set out2_ready=0 and send 2 beats with select=1. The first fills the slot, then in_ready=0 and the second beat stalls with its data held. Raising out2_ready drains A then B in order with no loss. Meanwhile a select=0 beat is not accepted until the stall clears.
- Full rate and wrap: stream 260 beats to out1 with ready held high. Expect 1 beat/cycle and out1_count=4 at the end (wrap at 256).
- Reset mid-stream: assert rst asynchronously while out2_valid=1. Both valids and counters drop to 0 immediately, and in_ready=1 after release.
- DEMUX_PKT_LOCK_EN: send a 3-beat packet with first select=1, then select toggling 0/1 on the remaining beats. All 3 beats go to out2. The next packet's first beat with select=0 goes to out1.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared route encodings and packet-lock state for the 1:2 stream demux
package demux_pkg;
  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;
  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output register slice with drain handling and a wrapping delivered-beat counter
module demux_out_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             writable,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] count
);
  logic drain;
  assign drain = valid && ready;
  assign writable = !valid || ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      if (load) begin
        data  <= ld_data;
        last  <= ld_last;
        valid <= 1'b1;
      end else if (drain) valid <= 1'b0;
      if (drain) count <= count + 1'b1;
    end
endmodule

// File: rtl/stream_demux1to2.sv
// stream_demux1to2: registered 1:2 valid/ready demux, one slot per output, 1-cycle latency
// DEMUX_PKT_LOCK_EN keeps every beat of a packet on the output chosen by its first beat
module stream_demux1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out1_count,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_last,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] out2_count
);
  logic sel_eff, acc, wr1, wr2;
`ifdef DEMUX_PKT_LOCK_EN
  lock_state_e state, state_nx;
  logic lock_sel, lock_sel_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= LOCK_IDLE;
      lock_sel <= SEL_OUT1;
    end else begin
      state    <= state_nx;
      lock_sel <= lock_sel_nx;
    end
  assign sel_eff = (state == LOCK_HELD) ? lock_sel : in_select;
  always_comb begin
    state_nx    = state;
    lock_sel_nx = lock_sel;
    if (acc && state == LOCK_IDLE && !in_last) begin
      state_nx    = LOCK_HELD;
      lock_sel_nx = in_select;
    end
    if (acc && state == LOCK_HELD && in_last) state_nx = LOCK_IDLE;
  end
`else
  assign sel_eff = in_select;
`endif
  assign in_ready = (sel_eff == SEL_OUT2) ? wr2 : wr1;
  assign acc = in_valid && in_ready;
  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk(clk), .rst(rst), .load(acc && sel_eff == SEL_OUT1), .ld_data(in_data), .ld_last(in_last),
    .writable(wr1), .data(out1_data), .last(out1_last), .valid(out1_valid), .ready(out1_ready),
    .count(out1_count)
  );
  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
    .clk(clk), .rst(rst), .load(acc && sel_eff == SEL_OUT2), .ld_data(in_data), .ld_last(in_last),
    .writable(wr2), .data(out2_data), .last(out2_last), .valid(out2_valid), .ready(out2_ready),
    .count(out2_count)
  );
endmodule

// File: tb/tb_stream_demux1to2.sv
// tb_stream_demux1to2: scoreboard bench for the 1:2 stream demux
module tb_stream_demux1to2;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_select = 1'b0, in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] out1_data, out2_data, out1_count, out2_count;
  logic out1_last, out2_last, out1_valid, out2_valid;
  logic out1_ready = 1'b0, out2_ready = 1'b0;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] expq[2][$];
  logic [8:0] gotq[2][$];
  logic m_full[2];
  int m_cnt[2];
  logic m_lock, m_lsel, rdy_exp, rdy_obs;

  stream_demux1to2 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_select(in_select), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_last(out1_last), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_count(out1_count),
    .out2_data(out2_data), .out2_last(out2_last), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out2_count(out2_count)
  );

  always #5 clk = ~clk;

  task automatic reset_model();
    m_full = '{1'b0, 1'b0};
    m_cnt = '{0, 0};
    m_lock = 1'b0;
    m_lsel = 1'b0;
    for (int o = 0; o < 2; o++) begin
      expq[o].delete();
      gotq[o].delete();
    end
  endtask

  // One clock of stimulus; records observed drains and model-expected beats, no checking here.
  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l,
                       input logic r1, input logic r2);
    logic se, acc, dr1, dr2;
    @(negedge clk);
    in_valid = v; in_select = s; in_data = d; in_last = l;
    out1_ready = r1; out2_ready = r2;
    #1;
`ifdef DEMUX_PKT_LOCK_EN
    se = m_lock ? m_lsel : s;
`else
    se = s;
`endif
    rdy_exp = se ? (!m_full[1] || r2) : (!m_full[0] || r1);
    rdy_obs = in_ready;
    if (out1_valid && out1_ready) gotq[0].push_back({out1_last, out1_data});
    if (out2_valid && out2_ready) gotq[1].push_back({out2_last, out2_data});
    acc = v && rdy_exp;
    dr1 = m_full[0] && r1;
    dr2 = m_full[1] && r2;
    if (acc) expq[se].push_back({l, d});
    @(posedge clk);
    m_full[0] = (acc && !se) ? 1'b1 : (dr1 ? 1'b0 : m_full[0]);
    m_full[1] = (acc && se) ? 1'b1 : (dr2 ? 1'b0 : m_full[1]);
    m_cnt[0] += int'(dr1);
    m_cnt[1] += int'(dr2);
    if (acc && !m_lock && !l) begin
      m_lock = 1'b1;
      m_lsel = s;
    end else if (acc && m_lock && l) m_lock = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    n_cmp += 5;
    if ({out1_valid, out2_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", {out1_valid, out2_valid}); end
    if ({out1_data, out2_data} !== 16'h0) begin n_bad++; $display("FAIL reset_data got %h want 0000", {out1_data, out2_data}); end
    if ({out1_last, out2_last} !== 2'b00) begin n_bad++; $display("FAIL reset_last got %b want 00", {out1_last, out2_last}); end
    if ({out1_count, out2_count} !== 16'h0) begin n_bad++; $display("FAIL reset_count got %h want 0000", {out1_count, out2_count}); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_route();
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    #2;
    n_cmp += 3;
    if (out1_valid !== 1'b1) begin n_bad++; $display("FAIL route_out1_valid got %b want 1", out1_valid); end
    if (out1_data !== 8'hA5) begin n_bad++; $display("FAIL route_out1_data got %h want a5", out1_data); end
    if (out2_valid !== 1'b0) begin n_bad++; $display("FAIL route_out2_valid got %b want 0", out2_valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #2;
    n_cmp++;
    if (out1_count !== 8'd1) begin n_bad++; $display("FAIL route_count got %0d want 1", out1_count); end
    for (int o = 0; o < 2; o++) begin
      n_cmp++;
      if (gotq[o].size() != expq[o].size()) begin n_bad++; $display("FAIL route_beats out%0d got %0d want %0d", o + 1, gotq[o].size(), expq[o].size()); end
      while (expq[o].size() > 0 && gotq[o].size() > 0) begin
        logic [8:0] e, g;
        e = expq[o].pop_front(); g = gotq[o].pop_front();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL route_beat out%0d got %h want %h", o + 1, g, e); end
      end
      expq[o].delete(); gotq[o].delete();
    end
  endtask

  task automatic test_steering();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] c;
      c = 3'(i);
      drive(1'b1, c[1], c[0] ? 8'h81 : 8'h18, c[2], 1'b1, 1'b1);
      #2;
      n_cmp += 2;
      if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL steer_in_ready case %0d got %b want %b", i, rdy_obs, rdy_exp); end
      if ({out2_valid, out1_valid} !== {m_full[1], m_full[0]}) begin
        n_bad++; $display("FAIL steer_valid case %0d got %b want %b", i, {out2_valid, out1_valid}, {m_full[1], m_full[0]});
      end
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    for (int o = 0; o < 2; o++) begin
      n_cmp++;
      if (gotq[o].size() != expq[o].size()) begin n_bad++; $display("FAIL steer_beats out%0d got %0d want %0d", o + 1, gotq[o].size(), expq[o].size()); end
      while (expq[o].size() > 0 && gotq[o].size() > 0) begin
        logic [8:0] e, g;
        e = expq[o].pop_front(); g = gotq[o].pop_front();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL steer_beat out%0d got %h want %h", o + 1, g, e); end
      end
      expq[o].delete(); gotq[o].delete();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (rdy_obs !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready got %b want 1", rdy_obs); end
    repeat (2) begin
      drive(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
      #2;
      n_cmp += 3;
      if (rdy_obs !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready got %b want 0", rdy_obs); end
      if (out2_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid got %b want 1", out2_valid); end
      if (out2_data !== 8'hAA) begin n_bad++; $display("FAIL bp_hold_data got %h want aa", out2_data); end
    end
    drive(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (rdy_obs !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", rdy_obs); end
    drive(1'b1, 1'b0, 8'hCC, 1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp += 2;
    if (gotq[1].size() != 2 || gotq[1][0] !== 9'h1AA || gotq[1][1] !== 9'h1BB) begin
      n_bad++; $display("FAIL bp_order out2 got %p want 1aa 1bb", gotq[1]);
    end
    if (gotq[0].size() != 1 || gotq[0][0] !== 9'h1CC) begin
      n_bad++; $display("FAIL bp_out1 got %p want 1cc", gotq[0]);
    end
    for (int o = 0; o < 2; o++) begin
      expq[o].delete(); gotq[o].delete();
    end
  endtask

  task automatic test_full_rate();
    int stalls = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b1);
      if (rdy_obs !== 1'b1) stalls++;
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #2;
    n_cmp += 3;
    if (stalls != 0) begin n_bad++; $display("FAIL rate_stalls got %0d want 0", stalls); end
    if (out1_count !== 8'd4) begin n_bad++; $display("FAIL rate_wrap_count got %0d want 4", out1_count); end
    if (gotq[0].size() != 260) begin n_bad++; $display("FAIL rate_beats got %0d want 260", gotq[0].size()); end
    for (int o = 0; o < 2; o++) begin
      while (expq[o].size() > 0 && gotq[o].size() > 0) begin
        logic [8:0] e, g;
        e = expq[o].pop_front(); g = gotq[o].pop_front();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL rate_beat out%0d got %h want %h", o + 1, g, e); end
      end
      expq[o].delete(); gotq[o].delete();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    #2;
    n_cmp++;
    if (out2_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid got %b want 1", out2_valid); end
    #1 rst = 1'b1;
    #1;
    n_cmp += 2;
    if ({out1_valid, out2_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_valid got %b want 00", {out1_valid, out2_valid}); end
    if ({out1_count, out2_count} !== 16'h0) begin n_bad++; $display("FAIL rmid_count got %h want 0000", {out1_count, out2_count}); end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
  endtask

`ifdef DEMUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp += 2;
    if (gotq[1].size() != 3 || gotq[1][0] !== 9'h011 || gotq[1][1] !== 9'h022 || gotq[1][2] !== 9'h133) begin
      n_bad++; $display("FAIL lock_out2 got %p want 011 022 133", gotq[1]);
    end
    if (gotq[0].size() != 1 || gotq[0][0] !== 9'h144) begin
      n_bad++; $display("FAIL lock_out1 got %p want 144", gotq[0]);
    end
    for (int o = 0; o < 2; o++) begin
      expq[o].delete(); gotq[o].delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_route();
    test_steering();
    test_backpressure();
    test_full_rate();
    test_reset_mid();
`ifdef DEMUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
